// File: rtl/bsg_fifo_1r1w_circ_if.sv
// Handshake bundle for the circular 1R1W FIFO.
// The producer uses valid/ready and the consumer uses valid/yumi.
interface bsg_fifo_1r1w_circ_if #(
    parameter int width_p = 8,
    parameter int els_p   = 16
);
    localparam int lg_els = $clog2(els_p);

    logic               v_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;
    logic               v_o;
    logic [width_p-1:0] data_o;
    logic               yumi_i;
    logic [lg_els:0]    count_o;

    // The FIFO side.
    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, count_o
    );

    // The producer/consumer side.
    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, count_o
    );
endinterface

// File: rtl/bsg_fifo_1r1w_circ.sv
// Single-clock 1R1W FIFO built from register-file storage and two circular pointers.
// A last-op flag tells full from empty when the two pointers are equal.
module bsg_fifo_1r1w_circ #(
    parameter int width_p = 8,
    parameter int els_p   = 16
) (
    input  logic                  clk,
    input  logic                  reset_i,
    bsg_fifo_1r1w_circ_if.slave   bus
);
    localparam int lg_els = $clog2(els_p);
    localparam int cnt_w  = lg_els + 1;

    logic [lg_els-1:0]  wptr_reg, wptr_next;
    logic [lg_els-1:0]  rptr_reg, rptr_next;
    logic               last_enq_reg, last_enq_next;
    logic [cnt_w-1:0]   count_reg, count_next;
    logic [width_p-1:0] mem [els_p];

    logic ptr_eq, full, empty, enq, deq;

    always_comb begin
        ptr_eq = (wptr_reg == rptr_reg);
        full   = ptr_eq & last_enq_reg;
        empty  = ptr_eq & ~last_enq_reg;
        enq    = bus.v_i & ~full;
        deq    = bus.yumi_i;
    end

    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        last_enq_next = last_enq_reg;
        count_next    = count_reg;

        // Pointers wrap naturally at lg_els bits because els_p is a power of two.
        if (enq) wptr_next = wptr_reg + lg_els'(1);
        if (deq) rptr_next = rptr_reg + lg_els'(1);

        unique case ({enq, deq})
            2'b10: begin
                last_enq_next = 1'b1;
                count_next    = count_reg + cnt_w'(1);
            end
            2'b01: begin
                last_enq_next = 1'b0;
                count_next    = count_reg - cnt_w'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            last_enq_reg <= 1'b0;
            count_reg    <= '0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            last_enq_reg <= last_enq_next;
            count_reg    <= count_next;
        end
    end

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (enq) mem[wptr_reg] <= bus.data_i;
    end

    assign bus.ready_o = ~full;
    assign bus.v_o     = ~empty;
    assign bus.data_o  = mem[rptr_reg];
    assign bus.count_o = count_reg;

    // A consumer may only take the head when one is presented.
    assert property (@(posedge clk) disable iff (reset_i) !(bus.yumi_i && !bus.v_o));
endmodule

// File: tb/tb_bsg_fifo_1r1w_circ.sv
// Bench for bsg_fifo_1r1w_circ: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_bsg_fifo_1r1w_circ;
    localparam int width_p = 8;
    localparam int els_p   = 16;

    logic clk;
    logic reset_i;

    bsg_fifo_1r1w_circ_if #(.width_p(width_p), .els_p(els_p)) bus ();

    bsg_fifo_1r1w_circ #(.width_p(width_p), .els_p(els_p)) dut (
        .clk     (clk),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    logic [width_p-1:0] model_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock of traffic: drive, check outputs against the model, clock, update the model.
    task automatic cycle(input logic v, input logic [width_p-1:0] d, input logic y);
        logic enq, deq;
        bus.v_i    = v;
        bus.data_i = d;
        bus.yumi_i = y;
        #1;
        check("ready", 32'(bus.ready_o), 32'(model_q.size() < els_p));
        check("v_o",   32'(bus.v_o),     32'(model_q.size() > 0));
        check("count", 32'(bus.count_o), 32'(model_q.size()));
        if (model_q.size() > 0) check("data_o", 32'(bus.data_o), 32'(model_q[0]));
        enq = v && (model_q.size() < els_p);
        deq = y && (model_q.size() > 0);
        $display("cyc %0d v_i=%0b data_i=%02h yumi_i=%0b enq=%0b deq=%0b occ=%0d",
                 cyc, v, d, y, enq, deq, model_q.size());
        @(posedge clk);
        cyc++;
        if (deq) void'(model_q.pop_front());
        if (enq) model_q.push_back(d);
        #1;
    endtask

    task automatic do_reset(input logic v, input logic [width_p-1:0] d);
        reset_i    = 1'b1;
        bus.v_i    = v;
        bus.data_i = d;
        bus.yumi_i = 1'b0;
        @(posedge clk);
        cyc++;
        model_q.delete();
        #1;
        reset_i = 1'b0;
        $display("cyc %0d reset (v_i=%0b)", cyc, v);
    endtask

    initial begin
        reset_i    = 1'b1;
        bus.v_i    = 1'b0;
        bus.data_i = '0;
        bus.yumi_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0, '0);

        // Reset then idle.
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0);

        // Fill back-to-back, then offer 0xAA while full.
        for (int i = 0; i < els_p; i++) cycle(1'b1, 8'(i), 1'b0);
        cycle(1'b1, 8'hAA, 1'b0);
        check("full_ready", 32'(bus.ready_o), 32'(0));
        check("full_count", 32'(bus.count_o), 32'(16));

        // Drain from full; ready returns the cycle after the first deq.
        cycle(1'b0, '0, 1'b1);
        check("ready_after_deq", 32'(bus.ready_o), 32'(1));
        for (int i = 1; i < els_p; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("drained_v", 32'(bus.v_o), 32'(0));

        // Wrap-around: park pointers at 10, then stream across the wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(8'h80 + i), model_q.size() > 0);
            check("wrap_cnt_le2", 32'(bus.count_o <= 2), 32'(1));
        end
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);

        // Simultaneous enq/deq at count 5.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0);
        cycle(1'b1, 8'h77, 1'b1);
        check("simul_count", 32'(bus.count_o), 32'(5));
        check("simul_head", 32'(bus.data_o), 32'(8'h51));
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);

        // Reset mid-operation with count 9 and enq asserted.
        for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        do_reset(1'b1, 8'hEE);
        check("rst_count", 32'(bus.count_o), 32'(0));
        check("rst_v", 32'(bus.v_o), 32'(0));
        check("rst_ready", 32'(bus.ready_o), 32'(1));
        cycle(1'b1, 8'h5C, 1'b0);
        check("post_rst_data", 32'(bus.data_o), 32'(8'h5C));
        cycle(1'b0, '0, 1'b1);

        // Random traffic with alternating fill-biased and drain-biased phases.
        for (int p = 0; p < 8; p++) begin
            for (int i = 0; i < 60; i++) begin
                logic v, y;
                v = (p % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
                y = ((p % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0))
                    && (model_q.size() > 0);
                cycle(v, 8'($urandom), y);
            end
        end
        while (model_q.size() > 0) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
